// File: rtl/multibyte_add_sequencer.sv
// Multi-precision adder sequencer: streams NBYTES operand bytes LSB first through
// an external 8-bit adder, chaining carry. Optional subtract mode under `SUB_EN.
module multibyte_add_sequencer #(
  parameter int NBYTES = 4,
  parameter int W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_cin,
`ifdef SUB_EN
  input  logic         sub,
`endif
  output logic [7:0]   add_a,
  output logic [7:0]   add_b,
  output logic         add_cin,
  input  logic [7:0]   add_s,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout
);

  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic          r_c;
  logic          r_sub;
  logic [IW-1:0] r_idx;
  logic          w_accept;
  logic          w_sub_in;
  logic [7:0]    w_b_byte;

`ifdef SUB_EN
  assign w_sub_in = sub;
`else
  assign w_sub_in = 1'b0;
`endif

  assign w_accept = in_valid && (r_state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_next = RUN;
      RUN:  if (r_idx == LAST) w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Subtraction is A + ~B + 1; the forced carry-in is loaded at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sum <= '0;
      r_c   <= 1'b0;
      r_sub <= 1'b0;
      r_idx <= '0;
    end else begin
      if (w_accept) begin
        r_a   <= op_a;
        r_b   <= op_b;
        r_sub <= w_sub_in;
        r_c   <= w_sub_in ? 1'b1 : op_cin;
        r_idx <= '0;
      end else if (r_state == RUN) begin
        r_sum[8*r_idx +: 8] <= add_s;
        r_c                 <= add_cout;
        r_idx               <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
      end
    end
  end

  assign w_b_byte = r_b[8*r_idx +: 8];

  always_comb begin
    add_a   = 8'h00;
    add_b   = 8'h00;
    add_cin = 1'b0;
    if (r_state == RUN) begin
      add_a   = r_a[8*r_idx +: 8];
      add_b   = r_sub ? ~w_b_byte : w_b_byte;
      add_cin = r_c;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_sum   = r_sum;
  assign out_cout  = r_c;

endmodule
